// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_JR        = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_AND    = 3'b100;
    localparam logic [2:0] ALUOP_SLT    = 3'b101;

    // Shift instructions take their first ALU operand from the shamt field.
    function automatic logic isShift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. The controller uses the master view.
interface multicycle_control_if;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic        ExtOp;
    logic        LuOp;
    logic [3:0]  ALUOp;
    logic        retire;
    logic        illegal;
    logic        mem_err;
    logic [3:0]  state_o;
    logic [31:0] instr_count;

    modport master (
        input  OpCode, Funct, Zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
               ExtOp, LuOp, ALUOp, retire, illegal, mem_err,
               state_o, instr_count
    );

    modport slave (
        output OpCode, Funct, Zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
               ExtOp, LuOp, ALUOp, retire, illegal, mem_err,
               state_o, instr_count
    );
endinterface

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the last allowed one.
// MEM_TIMEOUT = 0 never expires.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [W-1:0] count;

    // Stall counter, cleared whenever the controller is not holding in a wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (MEM_TIMEOUT != 0) && (count == LAST);
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. Optional retire counter under MC_CTRL_PERF_EN.
//
// state      | meaning
// INIT       | reset, all outputs low
// FETCH      | read instruction, PC+4 on ready
// DECODE     | read regs, precompute branch target
// MEM_ADDR   | effective address for lw/sw
// MEM_READ   | data read, wait for ready
// MEM_WB     | load result to rt
// MEM_WRITE  | data write, retires on ready
// R_EXEC     | R-type ALU operation
// R_WB       | R-type result to rd
// I_EXEC     | immediate ALU operation
// I_WB       | immediate result to rt
// BRANCH     | beq compare, conditional PC write
// JUMP       | j / jal
// JR         | jr / jalr
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
    state_t stateCur;
    state_t stateNext;
    logic   waitHold;
    logic   waitExpire;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uWaitTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!waitHold),
        .enable (waitHold),
        .expire (waitExpire)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateCur <= ST_INIT;
        end else begin
            stateCur <= stateNext;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        stateNext        = stateCur;
        waitHold         = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.RegDst       = REGDST_RT;
        bus.MemtoReg     = MEMTOREG_ALUOUT;
        bus.ALUSrcA      = SRCA_PC;
        bus.ALUSrcB      = SRCB_B;
        bus.PCSource     = PCSRC_ALU;
        bus.ExtOp        = 1'b0;
        bus.LuOp         = 1'b0;
        bus.ALUOp        = 4'b0000;
        bus.retire       = 1'b0;
        bus.illegal      = 1'b0;
        bus.mem_err      = 1'b0;

        case (stateCur)
            ST_INIT: stateNext = ST_FETCH;

            ST_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    stateNext   = ST_DECODE;
                end else if (waitExpire) begin
                    bus.mem_err = 1'b1;
                    stateNext   = ST_FETCH;
                end else begin
                    waitHold = 1'b1;
                end
            end

            ST_DECODE: begin
                bus.ALUSrcB = SRCB_IMMSH2;
                bus.ExtOp   = 1'b1;
                case (bus.OpCode)
                    OP_LW, OP_SW: stateNext = ST_MEM_ADDR;
                    OP_RTYPE: begin
                        if (bus.Funct == FN_JR || bus.Funct == FN_JALR) begin
                            stateNext = ST_JR;
                        end else begin
                            stateNext = ST_R_EXEC;
                        end
                    end
                    OP_BEQ:       stateNext = ST_BRANCH;
                    OP_J, OP_JAL: stateNext = ST_JUMP;
                    OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU:
                                  stateNext = ST_I_EXEC;
                    default: begin
                        bus.illegal = 1'b1;
                        stateNext   = ST_FETCH;
                    end
                endcase
            end

            ST_MEM_ADDR: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
                bus.ExtOp   = 1'b1;
                stateNext   = (bus.OpCode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end

            ST_MEM_READ: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) begin
                    stateNext = ST_MEM_WB;
                end else if (waitExpire) begin
                    bus.mem_err = 1'b1;
                    stateNext   = ST_FETCH;
                end else begin
                    waitHold = 1'b1;
                end
            end

            ST_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = REGDST_RT;
                bus.MemtoReg = MEMTOREG_MDR;
                bus.retire   = 1'b1;
                stateNext    = ST_FETCH;
            end

            ST_MEM_WRITE: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    stateNext  = ST_FETCH;
                end else if (waitExpire) begin
                    bus.mem_err = 1'b1;
                    stateNext   = ST_FETCH;
                end else begin
                    waitHold = 1'b1;
                end
            end

            ST_R_EXEC: begin
                bus.ALUSrcA = isShift(bus.Funct) ? SRCA_SHAMT : SRCA_A;
                bus.ALUSrcB = SRCB_B;
                bus.ALUOp   = {bus.OpCode[0], ALUOP_RTYPE};
                stateNext   = ST_R_WB;
            end

            ST_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = REGDST_RD;
                bus.MemtoReg = MEMTOREG_ALUOUT;
                bus.retire   = 1'b1;
                stateNext    = ST_FETCH;
            end

            ST_I_EXEC: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
                bus.LuOp    = (bus.OpCode == OP_LUI);
                bus.ExtOp   = !((bus.OpCode == OP_ANDI) || (bus.OpCode == OP_LUI));
                if (bus.OpCode == OP_ANDI) begin
                    bus.ALUOp = {bus.OpCode[0], ALUOP_AND};
                end else if (bus.OpCode == OP_SLTI || bus.OpCode == OP_SLTIU) begin
                    bus.ALUOp = {bus.OpCode[0], ALUOP_SLT};
                end else begin
                    bus.ALUOp = {bus.OpCode[0], ALUOP_ADD};
                end
                stateNext = ST_I_WB;
            end

            ST_I_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = REGDST_RT;
                bus.MemtoReg = MEMTOREG_ALUOUT;
                bus.retire   = 1'b1;
                stateNext    = ST_FETCH;
            end

            ST_BRANCH: begin
                // Zero gates the PC write in the datapath, not here.
                bus.ALUSrcA     = SRCA_A;
                bus.ALUSrcB     = SRCB_B;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = PCSRC_ALUOUT;
                bus.ALUOp       = {bus.OpCode[0], ALUOP_BRANCH};
                bus.retire      = 1'b1;
                stateNext       = ST_FETCH;
            end

            ST_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
                bus.retire   = 1'b1;
                if (bus.OpCode == OP_JAL) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = REGDST_RA;
                    bus.MemtoReg = MEMTOREG_PC;
                end
                stateNext = ST_FETCH;
            end

            ST_JR: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_A;
                bus.retire   = 1'b1;
                if (bus.Funct == FN_JALR) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = REGDST_RD;
                    bus.MemtoReg = MEMTOREG_PC;
                end
                stateNext = ST_FETCH;
            end

            default: stateNext = ST_INIT;
        endcase
    end

    assign bus.state_o = stateCur;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instrCount;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instrCount <= '0;
        end else if (bus.retire) begin
            instrCount <= instrCount + 32'd1;
        end
    end

    assign bus.instr_count = instrCount;
`else
    assign bus.instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, built with MEM_TIMEOUT = 4.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nChecks = 0;
    int   nFail = 0;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    wire [25:0] allOut = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                          bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst,
                          bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                          bus.ExtOp, bus.LuOp, bus.ALUOp, bus.retire,
                          bus.illegal, bus.mem_err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with ready, move into DECODE.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        bus.OpCode = op;
        bus.Funct = fn;
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(bus.state_o), 32'd1);
        check("fetch_irw_pcw", {30'd0, bus.IRWrite, bus.PCWrite}, 32'd3);
        step();
        bus.mem_ready = 1'b0;
        #1;
        check("decode_state", 32'(bus.state_o), 32'd2);
    endtask

    initial begin
        bus.OpCode = 6'h00;
        bus.Funct = 6'h00;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset held three cycles.
        repeat (3) step();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_outputs", 32'(allOut), 32'd0);
        check("rst_count", bus.instr_count, 32'd0);
        #2 reset = 1'b1;
        step();
        #1;
        check("post_rst_fetch", 32'(bus.state_o), 32'd1);
        check("post_rst_memread", {29'd0, bus.MemRead, bus.IorD, bus.IRWrite}, 32'b100);
        check("fetch_srcb", 32'(bus.ALUSrcB), 32'b01);

        // add: FETCH, DECODE, R_EXEC, R_WB.
        fetch(6'h00, 6'h20);
        check("decode_srcb_ext", {29'd0, bus.ALUSrcB, bus.ExtOp}, 32'b111);
        step();
        check("rexec_state", 32'(bus.state_o), 32'd7);
        check("rexec_srca", 32'(bus.ALUSrcA), 32'b01);
        check("rexec_aluop", 32'(bus.ALUOp), 32'b0010);
        step();
        check("rwb_state", 32'(bus.state_o), 32'd8);
        check("rwb_ctrl", {28'd0, bus.RegWrite, bus.RegDst, bus.retire}, 32'b1011);
        step();

        // lw with three stall cycles in MEM_READ.
        fetch(6'h23, 6'h00);
        step();
        check("memaddr_state", 32'(bus.state_o), 32'd3);
        check("memaddr_ctrl", {27'd0, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp}, 32'b01101);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.mem_ready = (i == 3);
            #1;
            check("memread_state", 32'(bus.state_o), 32'd4);
            check("memread_ctrl", {29'd0, bus.MemRead, bus.IorD, bus.mem_err}, 32'b110);
        end
        step();
        bus.mem_ready = 1'b0;
        check("memwb_state", 32'(bus.state_o), 32'd5);
        check("memwb_ctrl", {27'd0, bus.RegWrite, bus.MemtoReg, bus.retire, bus.illegal}, 32'b10110);
        step();

        // beq.
        fetch(6'h04, 6'h00);
        step();
        check("beq_state", 32'(bus.state_o), 32'd11);
        check("beq_ctrl", {24'd0, bus.PCWriteCond, bus.PCSource, bus.ALUOp, bus.PCWrite},
              32'b1_01_0001_0);
        step();

        // jal.
        fetch(6'h03, 6'h00);
        step();
        check("jal_state", 32'(bus.state_o), 32'd12);
        check("jal_ctrl", {23'd0, bus.PCWrite, bus.PCSource, bus.RegWrite, bus.RegDst,
                           bus.MemtoReg, bus.retire}, 32'b1_10_1_10_10_1);
        step();

        // jalr.
        fetch(6'h00, 6'h09);
        step();
        check("jalr_state", 32'(bus.state_o), 32'd13);
        check("jalr_ctrl", {23'd0, bus.PCWrite, bus.PCSource, bus.RegWrite, bus.RegDst,
                            bus.MemtoReg, bus.retire}, 32'b1_11_1_01_10_1);
        step();

        // jr: no register write.
        fetch(6'h00, 6'h08);
        step();
        check("jr_ctrl", {28'd0, bus.PCWrite, bus.PCSource, bus.RegWrite}, 32'b1110);
        step();

        // sll uses shamt.
        fetch(6'h00, 6'h00);
        step();
        check("sll_srca", 32'(bus.ALUSrcA), 32'b10);
        step();
        step();

        // andi: zero-extended, AND op.
        fetch(6'h0c, 6'h00);
        step();
        check("andi_state", 32'(bus.state_o), 32'd9);
        check("andi_ctrl", {25'd0, bus.ALUSrcB, bus.ExtOp, bus.LuOp, bus.ALUOp[2:0]},
              32'b10_0_0_100);
        check("andi_aluop", 32'(bus.ALUOp), 32'b0100);
        step();
        check("iwb_ctrl", {27'd0, bus.RegWrite, bus.RegDst, bus.retire, bus.mem_err},
              32'b10010);
        step();

        // sltiu: ALUOp[3] from OpCode[0].
        fetch(6'h0b, 6'h00);
        step();
        check("sltiu_ctrl", {27'd0, bus.ExtOp, bus.ALUOp}, 32'b1_1101);
        step();
        step();

        // lui.
        fetch(6'h0f, 6'h00);
        step();
        check("lui_ctrl", {26'd0, bus.ExtOp, bus.LuOp, bus.ALUOp}, 32'b0_1_1000);
        step();
        step();

        // sw ready on first MEM_WRITE cycle.
        fetch(6'h2b, 6'h00);
        step();
        step();
        bus.mem_ready = 1'b1;
        #1;
        check("sw_state", 32'(bus.state_o), 32'd6);
        check("sw_ctrl", {28'd0, bus.MemWrite, bus.IorD, bus.retire, bus.RegWrite}, 32'b1110);
        step();
        bus.mem_ready = 1'b0;
`ifdef MC_CTRL_PERF_EN
        check("instr_count", bus.instr_count, 32'd11);
`else
        check("instr_count", bus.instr_count, 32'd0);
`endif

        // Fetch timeout after four stalled cycles.
        for (int i = 0; i < 3; i++) begin
            check("to_wait_state", 32'(bus.state_o), 32'd1);
            check("to_wait_err", 32'(bus.mem_err), 32'd0);
            step();
        end
        check("to_err", {29'd0, bus.mem_err, bus.IRWrite, bus.PCWrite}, 32'b100);
        check("to_retire", 32'(bus.retire), 32'd0);
        step();
        check("to_refetch_state", 32'(bus.state_o), 32'd1);
        check("to_refetch_err", 32'(bus.mem_err), 32'd0);

        // Illegal opcode.
        fetch(6'h3f, 6'h00);
        check("illegal_ctrl", {28'd0, bus.illegal, bus.RegWrite, bus.PCWrite, bus.MemWrite},
              32'b1000);
        step();
        check("illegal_next", 32'(bus.state_o), 32'd1);
        check("illegal_pulse", 32'(bus.illegal), 32'd0);

        // Reset in the middle of a store abandons it.
        fetch(6'h2b, 6'h00);
        step();
        step();
        check("midrst_pre", 32'(bus.MemWrite), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_state", 32'(bus.state_o), 32'd0);
        check("midrst_outputs", 32'(allOut), 32'd0);
        check("midrst_count", bus.instr_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
